// File: rtl/keen_fetch_pkg.sv
// keen_fetch_pkg: shared types and helpers for the instruction fetch unit.
//   fetch_state_t : FETCH (normal streaming) / DRAIN (discarding stale responses)
//   ialign()      : instruction alignment in bytes (ILEN/8)
//   cnt_width()   : bits needed to hold a count of 0..depth inclusive
package keen_fetch_pkg;

    typedef enum logic [0:0] {
        FETCH,
        DRAIN
    } fetch_state_t;

    function automatic int unsigned ialign(input int unsigned ilen);
        return ilen / 8;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/keen_fetch_fifo.sv
// keen_fetch_fifo: synchronous FIFO with push/pop/clear and an occupancy count.
//   clk, reset_n    : clock, asynchronous active-low reset
//   clear           : empties the FIFO (wins over push and pop)
//   push, push_data : write an entry (ignored when full unless popping too)
//   pop             : drop the head entry (ignored when empty)
//   head            : current head entry (undefined when count == 0)
//   count           : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module keen_fetch_fifo
    import keen_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_q != '0);
    // Push on full is allowed only when the head leaves in the same cycle.
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/keen_instruction_fetch.sv
// keen_instruction_fetch: issues instruction memory requests for the current pc,
// pairs in-order responses with their addresses and buffers them toward decode.
// A branch flushes the buffer and discards every response still in flight.
//   clk, reset_n                       : clock, asynchronous active-low reset
//   pc, branch                         : fetch address and redirect from the program counter
//   pc_advance                         : request accepted this cycle, pc may step
//   imem_req_valid/ready, imem_req_addr: request channel (addr == pc)
//   imem_rsp_valid, imem_rsp_data      : in-order responses, no backpressure
//   inst_valid/ready, inst_data/pc     : buffered instructions toward decode
// Optional build macro KEEN_FETCH_MISALIGN_EN adds fetch_misaligned and blocks
// fetches from a pc that is not ILEN-aligned.
module keen_instruction_fetch
    import keen_fetch_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ILEN       = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc,
    input  logic            branch,
    output logic            pc_advance,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
`ifdef KEEN_FETCH_MISALIGN_EN
    ,
    output logic            fetch_misaligned
`endif
);

    localparam int unsigned CW = cnt_width(FIFO_DEPTH);

    fetch_state_t       state_q;
    logic [CW-1:0]      outstanding_q;
    logic [CW-1:0]      drop_q;
    logic [CW-1:0]      drop_after;
    logic [CW-1:0]      buf_count;
    logic [CW-1:0]      aq_count;
    logic [XLEN-1:0]    aq_head;
    logic [XLEN+ILEN-1:0] buf_head;
    logic               rsp_fire;
    logic               credit_ok;
    logic               misaligned;
    logic               buf_push;
    logic               buf_pop;

`ifdef KEEN_FETCH_MISALIGN_EN
    localparam int unsigned IALIGN = ialign(ILEN);
    logic misaligned_q;
    assign misaligned       = (pc & XLEN'(IALIGN - 1)) != '0;
    assign fetch_misaligned = misaligned_q;
`else
    assign misaligned = 1'b0;
`endif

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire   = imem_rsp_valid && (outstanding_q != '0);
    assign drop_after = outstanding_q - CW'(rsp_fire);
    // Never have more fetches in flight or buffered than the buffer can hold,
    // so a response always finds space.
    assign credit_ok  = ((CW+1)'(outstanding_q) + (CW+1)'(buf_count)) < (CW+1)'(FIFO_DEPTH);

    assign imem_req_valid = reset_n && (state_q == FETCH) && !branch && credit_ok && !misaligned;
    assign pc_advance     = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = pc;

    assign inst_valid = (state_q == FETCH) && (buf_count != '0);
    assign inst_pc    = buf_head[XLEN+ILEN-1:ILEN];
    assign inst_data  = buf_head[ILEN-1:0];

    // A flush takes priority over both a pop from decode and a fresh response.
    assign buf_pop  = inst_valid && inst_ready && !branch;
    assign buf_push = rsp_fire && (state_q == FETCH) && !branch;

    keen_fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_addr_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (1'b0),
        .push      (pc_advance),
        .push_data (pc),
        .pop       (rsp_fire),
        .head      (aq_head),
        .count     (aq_count)
    );

    keen_fetch_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (branch),
        .push      (buf_push),
        .push_data ({aq_head, imem_rsp_data}),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FETCH;
            outstanding_q <= '0;
            drop_q        <= '0;
`ifdef KEEN_FETCH_MISALIGN_EN
            misaligned_q  <= 1'b0;
`endif
        end else begin
            case ({pc_advance, rsp_fire})
                2'b10:   outstanding_q <= outstanding_q + CW'(1);
                2'b01:   outstanding_q <= outstanding_q - CW'(1);
                default: outstanding_q <= outstanding_q;
            endcase

            unique case (state_q)
                FETCH: begin
                    if (branch) begin
                        drop_q  <= drop_after;
                        state_q <= (drop_after != '0) ? DRAIN : FETCH;
                    end
                end
                DRAIN: begin
                    // Everything in flight here predates the redirect; a further
                    // branch changes nothing since no new requests were issued.
                    if (rsp_fire) begin
                        drop_q <= drop_q - CW'(1);
                        if (drop_q == CW'(1)) begin
                            state_q <= FETCH;
                        end
                    end
                end
                default: state_q <= FETCH;
            endcase

`ifdef KEEN_FETCH_MISALIGN_EN
            if (branch) begin
                misaligned_q <= 1'b0;
            end else if ((state_q == FETCH) && misaligned) begin
                misaligned_q <= 1'b1;
            end
`endif
        end
    end

`ifndef SYNTHESIS
    rsp_without_request: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rsp_valid |-> (outstanding_q != '0));
    addr_queue_tracks_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
        aq_count == outstanding_q);
`endif

endmodule
